// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM-stage load/store port.
// Ports: clk_i/rst_i, req_i/we_i/addr_i/wdata_i in; rdata_o/ready_o/err_o/stall_o out.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ready_o,
  output logic        err_o,
  output logic        stall_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW =
    (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT =
    CW'(LATENCY - 2);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [AW+1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            ready_q, ready_d;
  logic            err_q, err_d;

  logic            commit;
  logic            misal;
  logic [AW-1:0]   idx;
  logic [31:0]     mem [DEPTH_WORDS];

  // Upper address bits only alias the array.
  logic            unused_addr_hi;
  assign unused_addr_hi = ^addr_i[31:AW+2];

  assign idx   = addr_q[AW+1:2];
  assign misal = |addr_q[1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          we_d    = we_i;
          addr_d  = addr_i[AW+1:0];
          wdata_d = wdata_i;
          cnt_d   = CNT_INIT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          commit  = 1'b1;
          ready_d = 1'b1;
          err_d   = misal;
          rdata_d = (we_q || misal) ? '0 : mem[idx];
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Reset on the commit edge abandons the store.
  always_ff @(posedge clk_i) begin
    if (rst_i && commit && we_q && !misal) begin
      mem[idx] <= wdata_q;
    end
  end

  assign stall_o = ((state_q == IDLE) && req_i)
                || (state_q == BUSY);
  assign rdata_o = rdata_q;
  assign ready_o = ready_q;
  assign err_o   = err_q;

endmodule
